char_writer: RTL
================

Name: char_writer

Overview:
- Host-side writer for the character-row text buffers. It accepts a byte stream from the Arduino host interface over a valid/ready handshake and keeps a text cursor.
- It drives the write side of the row buffers: write strobe, row select, column address and 6-bit character code.
- It decodes a small set of control codes (newline, carriage return, backspace, clear screen).
- It gates every buffer write to a caller-supplied "write allowed" window, normally blanking, so writes never collide with scan-out reads.

Parameters:
- COLS, 80, characters per row (640 px / 8 px).
- ROWS, 48, character rows (480 px / 10 px).
- CLEAR_CHAR, 6'd0, code written to every cell by clear-screen.
- COL_W, 7, column counter width; must satisfy 2^COL_W >= COLS.
- ROW_W, 6, row counter width; must satisfy 2^ROW_W >= ROWS.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  block can accept a byte this cycle
- wr_allow  in  1  buffer writes permitted this cycle (blanking window)
- wr_en  out  1  one-cycle write strobe to the row buffers
- wr_row  out  ROW_W  target row; the row buffer whose index matches consumes wr_en
- wr_col  out  COL_W  target column / cell address within the row
- wr_char  out  6  character code to store
- cur_col  out  COL_W  current cursor column
- cur_row  out  ROW_W  current cursor row
- busy  out  1  high in WRITE or CLEAR

Behaviour:
- Reset (rst_n=0 at a clk edge), applied regardless of state:
  - state=IDLE; cur_col=0, cur_row=0.
  - wr_en=0, wr_row=0, wr_col=0, wr_char=0.
  - in_ready=0 during reset; busy=0.
  - Reset mid-WRITE or mid-CLEAR aborts the operation; no further wr_en.
- FSM states: IDLE, WRITE, CLEAR.
- in_ready = (state==IDLE) && rst_n. A byte is accepted when in_valid && in_ready at a rising edge.
- Decode of an accepted byte in IDLE:
  - 0x00-0x3F, printable:
    - latch wr_char=in_data[5:0], wr_row=cur_row, wr_col=cur_col.
    - go to WRITE.
  - 0x0A, LF: cur_col=0; cur_row=(cur_row==ROWS-1)?0:cur_row+1. Stay IDLE; no write.
  - 0x0D, CR: cur_col=0. Stay IDLE.
  - 0x08, BS: if cur_col>0 then cur_col-1, else no change. Row never changes. Stay IDLE.
  - 0x0C, FF/clear: load the clear pointer to row 0, col 0; go to CLEAR.
  - Any other byte: consumed and ignored; no state change.
- WRITE state:
  - wr_en=1 in each WRITE cycle in which wr_allow=1; wr_en=0 otherwise.
  - WRITE holds with outputs stable until wr_allow=1, so there is no lost write.
  - In the cycle wr_en=1, advance the cursor:
    - col==COLS-1 gives col=0 and row+1;
    - row==ROWS-1 with col==COLS-1 gives (0,0). Wrap only, no scroll.
  - Next state IDLE.
  - Minimum latency: byte accepted at edge N gives wr_en high in cycle N+1, and in_ready high again from cycle N+2.
- CLEAR state:
  - wr_char=CLEAR_CHAR; wr_row/wr_col = clear pointer.
  - wr_en=1 only when wr_allow=1. The pointer advances only on cycles with wr_en=1, column-major within a row, then next row.
  - After writing cell (ROWS-1, COLS-1): cursor=(0,0), state IDLE.
  - Total ROWS*COLS = 3840 strobes, each at a unique address.
- wr_en never asserts while wr_allow=0, and never in IDLE.
- busy = (state!=IDLE).
- Counter arithmetic is unsigned; compare against COLS-1 and ROWS-1 explicitly, never rely on natural overflow.
- in_valid high during WRITE/CLEAR: no accept, and the byte is held by the host (standard valid/ready).

Decomposition:
- Shared package (gpu_text_pkg) holds:
  - COLS, ROWS, COL_W, ROW_W, CHAR_W=6.
  - Control-code constants CC_LF=8'h0A, CC_CR=8'h0D, CC_BS=8'h08, CC_FF=8'h0C.
  - State enum {IDLE, WRITE, CLEAR}.
- One natural sub-module: text_cursor, a cursor counter with advance/newline/cr/backspace/home inputs and wrap logic. char_writer instantiates it and owns the FSM and the write-port registers.

Test Plan:
- Reset then wr_allow=1; send 0x05 -> wr_en=1 one cycle later with row 0, col 0, char 0x05; cursor ends at (0,1); in_ready deasserted for exactly one cycle.
- wr_allow=0, send 0x21 -> in_ready=0 and wr_en=0 for 20 cycles. Raise wr_allow -> exactly one wr_en with char 0x21 at (0,0).
- Cursor at (0,79), send 0x01 -> write at col 79, cursor becomes (1,0). At (47,79), send 0x01 -> cursor becomes (0,0).
- Control codes from cursor (3,10):
  - 0x0D -> (3,0).
  - 0x08 at col 0 -> (3,0) unchanged.
  - 0x0A at row 47 -> (0,0).
  - 0x7F -> ignored, no wr_en.
- Send 0x0C with wr_allow toggling 50% -> 3840 strobes, all addresses unique, char 0; busy cleared after; cursor (0,0).
- Assert rst_n=0 mid-CLEAR after 100 strobes -> next cycle wr_en=0, state IDLE, cursor (0,0), in_ready=1 after rst_n rises.

Source files
------------

// File: rtl/gpu_text_pkg.sv
// Shared geometry, control codes and FSM state type for the character-row text path.
// Imported by the host-side writer and its cursor counter.
package gpu_text_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 48;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 6;
    localparam int CHAR_W = 6;

    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_FF = 8'h0C;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_e;

    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == CC_LF) || (b == CC_CR) || (b == CC_BS) || (b == CC_FF);
    endfunction

    // Control codes sit inside 0x00-0x3F; they take priority over the glyph range.
    function automatic logic is_printable(input logic [7:0] b);
        return (b[7:6] == 2'b00) && !is_ctrl(b);
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Text cursor counter: advance with row wrap, newline, carriage return, backspace and home.
// Wraps to (0,0) past the last cell; there is no scrolling.
module text_cursor
    import gpu_text_pkg::*;
#(
    parameter int COLS  = gpu_text_pkg::COLS,
    parameter int ROWS  = gpu_text_pkg::ROWS,
    parameter int COL_W = gpu_text_pkg::COL_W,
    parameter int ROW_W = gpu_text_pkg::ROW_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_advance,
    input  logic             i_newline,
    input  logic             i_cr,
    input  logic             i_backspace,
    input  logic             i_home,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] w_col_nxt;
    logic [ROW_W-1:0] w_row_nxt;
    logic [ROW_W-1:0] w_row_inc;

    assign w_row_inc = (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);

    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (i_home) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end else if (i_advance) begin
            if (r_col == LAST_COL) begin
                w_col_nxt = '0;
                w_row_nxt = w_row_inc;
            end else begin
                w_col_nxt = r_col + COL_W'(1);
            end
        end else if (i_newline) begin
            w_col_nxt = '0;
            w_row_nxt = w_row_inc;
        end else if (i_cr) begin
            w_col_nxt = '0;
        end else if (i_backspace && (r_col != '0)) begin
            w_col_nxt = r_col - COL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    assign o_col = r_col;
    assign o_row = r_row;

endmodule

// File: rtl/char_writer.sv
// Host-side writer for the character-row buffers: accepts bytes over valid/ready, decodes
// control codes, and issues cell writes only inside the caller's wr_allow window.
module char_writer
    import gpu_text_pkg::*;
#(
    parameter int                COLS       = gpu_text_pkg::COLS,
    parameter int                ROWS       = gpu_text_pkg::ROWS,
    parameter logic [CHAR_W-1:0] CLEAR_CHAR = 6'd0,
    parameter int                COL_W      = gpu_text_pkg::COL_W,
    parameter int                ROW_W      = gpu_text_pkg::ROW_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              wr_allow,
    output logic              wr_en,
    output logic [ROW_W-1:0]  wr_row,
    output logic [COL_W-1:0]  wr_col,
    output logic [CHAR_W-1:0] wr_char,
    output logic [COL_W-1:0]  cur_col,
    output logic [ROW_W-1:0]  cur_row,
    output logic              busy
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ROW_W-1:0]  r_wr_row;
    logic [COL_W-1:0]  r_wr_col;
    logic [CHAR_W-1:0] r_wr_char;

    logic w_accept;
    logic w_strobe;
    logic w_clr_last;
    logic w_is_lf;
    logic w_is_cr;
    logic w_is_bs;
    logic w_is_ff;
    logic w_is_print;
    logic w_cur_adv;
    logic w_cur_nl;
    logic w_cur_cr;
    logic w_cur_bs;
    logic w_cur_home;

    assign w_is_lf    = (in_data == CC_LF);
    assign w_is_cr    = (in_data == CC_CR);
    assign w_is_bs    = (in_data == CC_BS);
    assign w_is_ff    = (in_data == CC_FF);
    assign w_is_print = is_printable(in_data);
    assign w_accept   = in_valid && in_ready;
    assign w_clr_last = (r_wr_row == LAST_ROW) && (r_wr_col == LAST_COL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_ff) begin
                    w_state_nxt = CLEAR;
                end else if (w_accept && w_is_print) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (wr_allow) begin
                    w_state_nxt = IDLE;
                end
            end
            CLEAR: begin
                if (wr_allow && w_clr_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // rst_n gating keeps a strobe from reaching the buffers on the edge that aborts an operation.
    always_comb begin
        in_ready   = (r_state == IDLE) && rst_n;
        busy       = (r_state != IDLE);
        w_strobe   = (r_state != IDLE) && wr_allow && rst_n;
        wr_en      = w_strobe;
        w_cur_adv  = (r_state == WRITE) && w_strobe;
        w_cur_home = (r_state == CLEAR) && w_strobe && w_clr_last;
        w_cur_nl   = w_accept && w_is_lf;
        w_cur_cr   = w_accept && w_is_cr;
        w_cur_bs   = w_accept && w_is_bs;
    end

    // In CLEAR the write address registers double as the clear pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_row  <= '0;
            r_wr_col  <= '0;
            r_wr_char <= '0;
        end else if (w_accept && w_is_ff) begin
            r_wr_row  <= '0;
            r_wr_col  <= '0;
            r_wr_char <= CLEAR_CHAR;
        end else if (w_accept && w_is_print) begin
            r_wr_row  <= cur_row;
            r_wr_col  <= cur_col;
            r_wr_char <= in_data[CHAR_W-1:0];
        end else if ((r_state == CLEAR) && w_strobe) begin
            if (r_wr_col == LAST_COL) begin
                r_wr_col <= '0;
                r_wr_row <= (r_wr_row == LAST_ROW) ? '0 : r_wr_row + ROW_W'(1);
            end else begin
                r_wr_col <= r_wr_col + COL_W'(1);
            end
        end
    end

    assign wr_row  = r_wr_row;
    assign wr_col  = r_wr_col;
    assign wr_char = r_wr_char;

    text_cursor #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_cursor (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_advance   (w_cur_adv),
        .i_newline   (w_cur_nl),
        .i_cr        (w_cur_cr),
        .i_backspace (w_cur_bs),
        .i_home      (w_cur_home),
        .o_col       (cur_col),
        .o_row       (cur_row)
    );

endmodule
